avl_mem_responder: RTL and testbench



---
 rtl/avl_resp_pkg.sv | 9 +
 rtl/avl_resp_ram.sv | 23 ++
 rtl/avl_mem_responder.sv | 125 ++++++++++++
 tb/tb_avl_mem_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/avl_resp_pkg.sv
// avl_resp_pkg: shared types and constants for the Avalon memory responder
// Contents: FSM state enum, LFSR seed and tap mask, transfer counter width.
package avl_resp_pkg;
   typedef enum logic [1:0] {INIT, IDLE, WAIT, ACK} state_t;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // taps 16,14,13,11 of a Fibonacci LFSR, as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_TAPS = 16'hB400;
   localparam int CNT_W = 32;
endpackage

// File: rtl/avl_resp_ram.sv
// avl_resp_ram: single-port synchronous RAM with registered read output
// Ports: iCLK clock, iRST_n sync active-low reset (clears only the read register),
//        we write enable, re read enable, addr word address, wdata write data,
//        rdata registered read data (holds between reads).
module avl_resp_ram #(
   parameter int DATA_W = 32,
   parameter int MEM_AW = 10
) (
   input  logic              iCLK,
   input  logic              iRST_n,
   input  logic              we,
   input  logic              re,
   input  logic [MEM_AW-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**MEM_AW];
   always_ff @(posedge iCLK)
      if (we) mem[addr] <= wdata;
   always_ff @(posedge iCLK)
      if (!iRST_n) rdata <= '0;
      else if (re) rdata <= mem[addr];
endmodule

// File: rtl/avl_mem_responder.sv
// avl_mem_responder: Avalon-MM slave standing in for the DDR controller
// Ports: iCLK/iRST_n clock and sync active-low reset; local_init_done ready flag;
//        avl_* Avalon-MM single-word slave (burstbegin ignored); wr_cnt/rd_cnt
//        accepted transfer counters; proto_err sticky protocol violation flag.
// Optional: define AVL_RESP_RANDOM_WAIT_EN to add 0..7 pseudo-random wait states.
module avl_mem_responder
   import avl_resp_pkg::*;
#(
   parameter int ADDR_W      = 27,
   parameter int DATA_W      = 32,
   parameter int MEM_AW      = 10,
   parameter int WAIT_CYCLES = 2,
   parameter int READ_LAT    = 3,
   parameter int INIT_CYCLES = 16
) (
   input  logic              iCLK,
   input  logic              iRST_n,
   output logic              local_init_done,
   input  logic [ADDR_W-1:0] avl_address,
   input  logic              avl_read,
   input  logic              avl_write,
   input  logic              avl_burstbegin,
   input  logic [DATA_W-1:0] avl_writedata,
   output logic              avl_waitrequest_n,
   output logic [DATA_W-1:0] avl_readdata,
   output logic              avl_readdatavalid,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic              proto_err
);
`ifdef AVL_RESP_RANDOM_WAIT_EN
   localparam int WCW = 5;
`else
   localparam int WCW = 4;
`endif
   localparam int INIT_W = $clog2(INIT_CYCLES + 1);
   state_t state, state_nx;
   logic [INIT_W-1:0] init_cnt;
   logic [WCW-1:0] wcnt, wait_ld;
   logic req_wr, req, req_line, conflict, abort, wr_acc, rd_acc, unused;
   logic [MEM_AW-1:0] req_addr;
   logic [DATA_W-1:0] req_data, ram_q;
   logic [READ_LAT-1:0] vp;
   assign unused = ^{avl_burstbegin, avl_address};
   assign req = avl_read | avl_write;
   // the line that must stay high while waiting is the one that was latched
   assign req_line = req_wr ? avl_write : avl_read;
`ifdef AVL_RESP_RANDOM_WAIT_EN
   logic [15:0] lfsr;
   always_ff @(posedge iCLK)
      lfsr <= !iRST_n ? LFSR_SEED : {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
   assign wait_ld = WCW'(WAIT_CYCLES) + WCW'(lfsr[2:0]);
`else
   assign wait_ld = WCW'(WAIT_CYCLES);
`endif
   always_ff @(posedge iCLK)
      state <= !iRST_n ? INIT : state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         INIT:    state_nx = (init_cnt == INIT_W'(INIT_CYCLES - 1)) ? IDLE : INIT;
         IDLE:    state_nx = !req ? IDLE : (wait_ld == '0) ? ACK : WAIT;
         WAIT:    state_nx = !req_line ? IDLE : (wcnt == WCW'(1)) ? ACK : WAIT;
         ACK:     state_nx = IDLE;
         default: state_nx = INIT;
      endcase
   end
   always_comb begin
      avl_waitrequest_n = state == ACK;
      wr_acc = (state == ACK) & req_wr;
      rd_acc = (state == ACK) & ~req_wr;
      conflict = (state == IDLE) & avl_read & avl_write;
      abort = (state == WAIT) & ~req_line;
   end
   always_ff @(posedge iCLK)
      if (!iRST_n) begin
         init_cnt <= '0;
         local_init_done <= 1'b0;
         wcnt <= '0;
         req_wr <= 1'b0;
         req_addr <= '0;
         req_data <= '0;
         wr_cnt <= '0;
         rd_cnt <= '0;
         proto_err <= 1'b0;
         vp <= '0;
      end else begin
         if (state == INIT) init_cnt <= init_cnt + 1'b1;
         if (state == INIT && state_nx == IDLE) local_init_done <= 1'b1;
         if (state == IDLE && req) begin
            req_wr <= avl_write;
            req_addr <= avl_address[MEM_AW-1:0];
            req_data <= avl_writedata;
            wcnt <= wait_ld;
         end else if (state == WAIT) wcnt <= wcnt - 1'b1;
         if (wr_acc) wr_cnt <= wr_cnt + 1'b1;
         if (rd_acc) rd_cnt <= rd_cnt + 1'b1;
         if (conflict | abort) proto_err <= 1'b1;
         vp <= READ_LAT'({vp, rd_acc});
      end
   avl_resp_ram #(.DATA_W(DATA_W), .MEM_AW(MEM_AW)) u_ram (
      .iCLK(iCLK),
      .iRST_n(iRST_n),
      .we(wr_acc),
      .re(rd_acc),
      .addr(req_addr),
      .wdata(req_data),
      .rdata(ram_q)
   );
   assign avl_readdatavalid = vp[READ_LAT-1];
   // the RAM output register is the first latency stage; the rest follow the valid bits
   if (READ_LAT == 1) begin : g_direct
      assign avl_readdata = ram_q;
   end else begin : g_pipe
      logic [DATA_W-1:0] dp [1:READ_LAT-1];
      always_ff @(posedge iCLK)
         if (!iRST_n) begin
            for (int i = 1; i < READ_LAT; i++) dp[i] <= '0;
         end else begin
            if (vp[0]) dp[1] <= ram_q;
            for (int i = 2; i < READ_LAT; i++) if (vp[i-1]) dp[i] <= dp[i-1];
         end
      assign avl_readdata = dp[READ_LAT-1];
   end
endmodule

// File: tb/tb_avl_mem_responder.sv
// tb_avl_mem_responder: directed plus randomized checks of avl_mem_responder against a memory model
module tb_avl_mem_responder;
   localparam int AW = 27, DW = 32, MAW = 10, WC = 2, RL = 3, IC = 16;
   logic iCLK = 0, iRST_n = 0;
   logic local_init_done, avl_read = 0, avl_write = 0, avl_burstbegin = 0;
   logic [AW-1:0] avl_address = '0;
   logic [DW-1:0] avl_writedata = '0, avl_readdata;
   logic avl_waitrequest_n, avl_readdatavalid, proto_err;
   logic [31:0] wr_cnt, rd_cnt;
   int n_cmp = 0, n_err = 0;
   logic [31:0] mem_m [1024];
   bit known [1024];
   int unsigned exp_wr = 0, exp_rd = 0;
   bit exp_pe = 0;

   avl_mem_responder #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_AW(MAW),
      .WAIT_CYCLES(WC), .READ_LAT(RL), .INIT_CYCLES(IC)
   ) dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .local_init_done(local_init_done),
      .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
      .avl_burstbegin(avl_burstbegin), .avl_writedata(avl_writedata),
      .avl_waitrequest_n(avl_waitrequest_n), .avl_readdata(avl_readdata),
      .avl_readdatavalid(avl_readdatavalid), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt),
      .proto_err(proto_err)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   // reset, check reset values, count cycles to local_init_done; optionally pulse a write at cycle 5
   task automatic do_reset(input bit pulse);
      int c;
      bit ack;
      iRST_n = 0; avl_read = 0; avl_write = 0;
      step(); step();
      iRST_n = 1;
      exp_wr = 0; exp_rd = 0; exp_pe = 0;
      chk("rst_done", local_init_done, 0);
      chk("rst_waitreq_n", avl_waitrequest_n, 0);
      chk("rst_rdvalid", avl_readdatavalid, 0);
      chk("rst_rdata", avl_readdata, 0);
      chk("rst_wr_cnt", wr_cnt, 0);
      chk("rst_rd_cnt", rd_cnt, 0);
      chk("rst_proto_err", proto_err, 0);
      c = 0; ack = 0;
      while (!local_init_done && c < 100) begin
         avl_write = pulse && (c == 5);
         avl_address = 27'd3;
         ack |= avl_waitrequest_n;
         step();
         c++;
      end
      avl_write = 0;
      chk("init_latency", c, IC);
      if (pulse) begin
         chk("init_no_ack", ack, 0);
         chk("init_proto_err", proto_err, 0);
      end
   endtask

   task automatic do_xfer(input bit wr, input bit both, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n, k, idx;
      logic [DW-1:0] exp_d;
      idx = int'(a[MAW-1:0]);
      avl_address = a; avl_writedata = d;
      avl_write = wr | both; avl_read = !wr | both;
      n = 0;
      while (!avl_waitrequest_n && n < 40) begin step(); n++; end
`ifdef AVL_RESP_RANDOM_WAIT_EN
      chk("ack_latency_range", (n >= 1 + WC && n <= 1 + WC + 7), 1);
`else
      chk("ack_latency", n, 1 + WC);
`endif
      step();
      avl_write = 0; avl_read = 0;
      if (wr | both) begin
         mem_m[idx] = d; known[idx] = 1; exp_wr++;
         if (both) exp_pe = 1;
      end else begin
         exp_rd++;
         exp_d = mem_m[idx];
         k = 1;
         while (!avl_readdatavalid && k < 20) begin step(); k++; end
         chk("rd_latency", k, RL);
         chk("rd_data", avl_readdata, exp_d);
      end
      chk("wr_cnt", wr_cnt, exp_wr);
      chk("rd_cnt", rd_cnt, exp_rd);
      chk("proto_err", proto_err, exp_pe);
   endtask

   initial begin
      int n;
      bit seen;
      logic [AW-1:0] a;
      do_reset(1);
      do_xfer(1, 0, 27'd5, 32'hDEAD_BEEF);
      do_xfer(0, 0, 27'd5, '0);
      chk("wb_wr_cnt_1", wr_cnt, 1);
      chk("wb_rd_cnt_1", rd_cnt, 1);
      do_xfer(1, 0, 27'h400, 32'h1234_5678);
      do_xfer(0, 0, 27'd0, '0);
      do_xfer(1, 1, 27'd7, 32'hA5A5_A5A5);
      chk("both_proto_err", proto_err, 1);
      do_xfer(0, 0, 27'd7, '0);
      do_xfer(1, 0, 27'd9, 32'h1111_1111);
      repeat (80) begin
         a = AW'($urandom);
         if (known[int'(a[MAW-1:0])] && $urandom_range(0, 1) == 1) do_xfer(0, 0, a, '0);
         else do_xfer(1, 0, a, $urandom);
      end
      // reset one cycle after a read acceptance edge: the in-flight read must vanish
      avl_address = 27'd5; avl_read = 1;
      n = 0;
      while (!avl_waitrequest_n && n < 40) begin step(); n++; end
      step();
      avl_read = 0;
      iRST_n = 0;
      step();
      iRST_n = 1;
      exp_wr = 0; exp_rd = 0; exp_pe = 0;
      seen = 0;
      repeat (6) begin seen |= avl_readdatavalid; step(); end
      chk("midrd_no_valid", seen, 0);
      chk("midrd_wr_cnt", wr_cnt, 0);
      chk("midrd_rd_cnt", rd_cnt, 0);
      n = 0;
      while (!local_init_done && n < 100) begin step(); n++; end
      chk("midrd_reinit", local_init_done, 1);
      do_xfer(0, 0, 27'd5, '0);
      // drop the write line while waiting: no commit, no count, sticky error
      do_reset(0);
      avl_address = 27'd9; avl_writedata = 32'h2222_2222; avl_write = 1;
      step();
      avl_write = 0;
      seen = 0;
      repeat (12) begin seen |= avl_waitrequest_n; step(); end
      exp_pe = 1;
      chk("drop_no_ack", seen, 0);
      chk("drop_proto_err", proto_err, 1);
      chk("drop_wr_cnt", wr_cnt, 0);
      do_xfer(0, 0, 27'd9, '0);
      // full write-all / read-all sweep
      do_reset(0);
      for (int i = 0; i < 1024; i++) do_xfer(1, 0, AW'(i), $urandom);
      for (int i = 0; i < 1024; i++) do_xfer(0, 0, AW'(i), '0);
      chk("sweep_wr_cnt", wr_cnt, 1024);
      chk("sweep_rd_cnt", rd_cnt, 1024);
      chk("sweep_proto_err", proto_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
